// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch unit: requests one word, holds it until
// decode consumes it, and follows redirects (misaligned targets lock the unit up).
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic        func7,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        misalign_q, misalign_d;
  logic        redirect_aligned;

  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    misalign_d   = misalign_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ, HOLD: begin
        // Redirect outranks both a memory response and a consume in the same cycle.
        if (redirect) begin
          inst_d       = NOP_INST;
          inst_valid_d = 1'b0;
          if (redirect_aligned) begin
            pc_d    = redirect_pc;
            state_d = REQ;
          end else begin
            misalign_d = 1'b1;
            state_d    = ERR;
          end
        end else if (state_q == REQ) begin
          if (imem_ready) begin
            inst_d       = imem_rdata;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (inst_ready) begin
          pc_d         = pc_q + 32'd4;
          inst_d       = NOP_INST;
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end

      ERR: begin
        state_d = ERR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req     = (state_q == REQ);
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign inst         = inst_q;
  assign inst_valid   = inst_valid_q;
  assign misalign_err = misalign_q;
  assign opcode       = inst_q[6:0];
  assign func3        = inst_q[14:12];
  assign func7        = inst_q[30];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: fetch, stalls, hold, redirects, wrap, error lock and reset.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  ifetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .pc          (pc),
    .opcode      (opcode),
    .func3       (func3),
    .func7       (func7),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    imem_rdata  = 32'h0;
    imem_ready  = 1'b0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state
    tick();
    check("rst_req", imem_req, 0);
    check("rst_pc", pc, 0);
    check("rst_inst", inst, NOP);
    check("rst_valid", inst_valid, 0);
    check("rst_merr", misalign_err, 0);

    // Basic fetch: IDLE, then request at 0, then held word
    rst        = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h0050_0093;
    inst_ready = 1'b1;
    tick();
    check("f_req", imem_req, 1);
    check("f_addr", imem_addr, 32'h0);
    check("f_valid0", inst_valid, 0);
    tick();
    check("f_valid", inst_valid, 1);
    check("f_inst", inst, 32'h0050_0093);
    check("f_opcode", opcode, 32'h13);
    check("f_func3", func3, 0);
    check("f_func7", func7, 0);
    check("f_hold_req", imem_req, 0);
    tick();
    check("f_next_req", imem_req, 1);
    check("f_next_addr", imem_addr, 32'h4);
    check("f_next_valid", inst_valid, 0);
    check("f_next_inst", inst, NOP);

    // Memory stall in REQ for 3 cycles
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_addr", imem_addr, 32'h4);
      check("st_req", imem_req, 1);
      check("st_valid", inst_valid, 0);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'h40B5_0533;
    inst_ready = 1'b0;
    tick();
    check("st_valid1", inst_valid, 1);
    check("st_inst", inst, 32'h40B5_0533);
    check("st_func7", func7, 1);
    check("st_func3", func3, 0);
    check("st_opcode", opcode, 32'h33);

    // Decode stall in HOLD for 2 cycles
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("h_valid", inst_valid, 1);
      check("h_inst", inst, 32'h40B5_0533);
      check("h_pc", pc, 32'h4);
      check("h_req", imem_req, 0);
    end
    inst_ready = 1'b1;
    tick();
    check("h_adv_pc", pc, 32'h8);
    check("h_adv_valid", inst_valid, 0);
    check("h_adv_req", imem_req, 1);

    // Redirect in REQ while memory returns data: data discarded
    imem_ready  = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    check("r_valid", inst_valid, 0);
    check("r_inst", inst, NOP);
    check("r_addr", imem_addr, 32'h100);
    check("r_req", imem_req, 1);
    redirect   = 1'b0;
    imem_rdata = 32'h0000_0013;
    inst_ready = 1'b0;
    tick();
    check("r_fetch_valid", inst_valid, 1);
    check("r_fetch_pc", pc, 32'h100);

    // Redirect from HOLD to the top word, fetch and consume -> wrap to 0
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    check("w_addr", imem_addr, 32'hFFFF_FFFC);
    check("w_valid", inst_valid, 0);
    redirect   = 1'b0;
    imem_rdata = 32'h0010_0073;
    inst_ready = 1'b1;
    tick();
    check("w_valid1", inst_valid, 1);
    check("w_inst", inst, 32'h0010_0073);
    tick();
    check("w_wrap_addr", imem_addr, 32'h0);
    check("w_wrap_req", imem_req, 1);

    // Fetch into HOLD, then misaligned redirect -> ERR
    inst_ready = 1'b0;
    imem_rdata = 32'h0050_0093;
    tick();
    check("e_hold_valid", inst_valid, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    check("e_merr", misalign_err, 1);
    check("e_valid", inst_valid, 0);
    check("e_inst", inst, NOP);
    check("e_pc", pc, 32'h0);
    check("e_req", imem_req, 0);
    // Inputs ignored in ERR, including an aligned redirect
    redirect_pc = 32'h0000_0200;
    inst_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("e_lock_req", imem_req, 0);
      check("e_lock_merr", misalign_err, 1);
      check("e_lock_pc", pc, 32'h0);
      redirect = 1'b0;
    end

    // Asynchronous reset clears the error without a clock edge
    #2 rst = 1'b1;
    #1;
    check("ar_merr", misalign_err, 0);
    check("ar_pc", pc, 32'h0);
    check("ar_req", imem_req, 0);
    tick();
    rst        = 1'b0;
    imem_ready = 1'b1;
    inst_ready = 1'b0;
    imem_rdata = 32'h0050_0093;
    tick();
    check("ar_first_req", imem_req, 1);
    check("ar_first_addr", imem_addr, 32'h0);
    tick();
    check("ar_hold_valid", inst_valid, 1);

    // Reset in HOLD discards the held instruction
    #2 rst = 1'b1;
    #1;
    check("rh_valid", inst_valid, 0);
    check("rh_inst", inst, NOP);
    tick();
    rst = 1'b0;
    tick();
    check("rh_req", imem_req, 1);
    check("rh_addr", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: the fetch address after reset, word-aligned.
REQ-003 Parameter NOP_INST, default 32'h0000_0013: the value held on inst when no instruction is valid.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 imem_req  output  1  fetch request to instruction memory.
REQ-007 imem_addr  output  32  fetch address; SHALL equal pc at all times.
REQ-008 imem_rdata  input  32  instruction word; sampled only when imem_req=1 and imem_ready=1.
REQ-009 imem_ready  input  1  memory accepts the request and returns data in the same cycle.
REQ-010 inst_ready  input  1  decode/execute consumes the held instruction.
REQ-011 redirect  input  1  control-flow change (taken branch, jal, jalr).
REQ-012 redirect_pc  input  32  target address used when redirect=1.
REQ-013 inst_valid  output  1  inst, pc, opcode, func3 and func7 are valid.
REQ-014 inst  output  32  held instruction word.
REQ-015 pc  output  32  address of the held or pending instruction.
REQ-016 opcode  output  7  inst[6:0], combinational from the held inst.
REQ-017 func3  output  3  inst[14:12], combinational from the held inst.
REQ-018 func7  output  1  inst[30], combinational from the held inst.
REQ-019 misalign_err  output  1  sticky flag: a redirect target was not word-aligned.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, HOLD and ERR, encoded as 2 bits.
REQ-021 IDLE: imem_req=0; the FSM SHALL go to REQ on the next edge unconditionally.
REQ-022 REQ: imem_req=1.
  - imem_ready=1 and redirect=0: inst<=imem_rdata, inst_valid<=1, go to HOLD.
  - imem_ready=0: stay in REQ; pc, imem_addr and imem_req SHALL be held.
REQ-023 HOLD: imem_req=0 and inst_valid=1.
  - inst_ready=1 and redirect=0: pc<=pc+4, inst<=NOP_INST, inst_valid<=0, go to REQ.
  - inst_ready=0 and redirect=0: all outputs SHALL be held.
REQ-024 Redirect with aligned target (redirect_pc[1:0]=0), in REQ or HOLD, regardless of imem_ready or inst_ready:
  - pc<=redirect_pc, inst<=NOP_INST, inst_valid<=0, go to REQ.
  - Any imem_rdata returned in that cycle SHALL be discarded.
REQ-025 Redirect with misaligned target (redirect_pc[1:0]!=0), in REQ or HOLD: misalign_err<=1, inst_valid<=0, inst<=NOP_INST, pc unchanged, go to ERR.
REQ-026 ERR is absorbing: imem_req=0, inst_valid=0, and all inputs are ignored until rst.
REQ-027 Redirect SHALL be ignored in IDLE.
REQ-028 pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-029 Latency: imem_ready=1 in REQ in cycle N gives inst_valid=1 in cycle N+1. Peak throughput is one instruction per 2 cycles.
REQ-030 All state and outputs SHALL be registered, except imem_req, imem_addr, opcode, func3 and func7, which are combinational from registers only.

Reset
REQ-031 While rst=1, asynchronously and independently of clk:
  - state=IDLE, pc=RESET_PC, inst=NOP_INST;
  - inst_valid=0, imem_req=0, misalign_err=0.
REQ-032 Reset asserted mid-fetch or in HOLD SHALL discard the pending instruction. After release, the first request SHALL be for RESET_PC, one cycle after IDLE.

Verification
REQ-033 Release reset, imem_ready=1, imem_rdata=32'h00500093, inst_ready=1 -> imem_req=1 with addr 0x0 in cycle 2; in cycle 3, inst_valid=1, opcode=7'h13, func3=0, func7=0; the next request is at addr 0x4.
REQ-034 In REQ, imem_ready=0 for 3 cycles, then 1 -> imem_addr stable for 4 cycles; inst_valid rises the cycle after ready.
REQ-035 In HOLD with inst 32'h40B50533, inst_ready=0 for 2 cycles -> inst, pc and inst_valid held; func7=1, func3=0; consume advances pc by 4.
REQ-036 In REQ, imem_ready=1 and redirect=1 with redirect_pc=0x100 in the same cycle -> data discarded, inst_valid stays 0, next imem_addr=0x100.
REQ-037 redirect_pc=0x102 in HOLD -> misalign_err=1 and inst_valid=0 next cycle; imem_req stays 0 until rst, and rst clears misalign_err.
REQ-038 Set pc=0xFFFFFFFC via redirect, fetch and consume -> the next imem_addr is 0x00000000.
